lfsr_rr_sched: RTL and testbench

LFSR_RR_SCHED -- requirements
Module: lfsr_rr_sched

---
 rtl/lfsr_pkg.sv | 18 +
 rtl/lfsr_rr_sched_if.sv | 26 ++
 rtl/lfsr_core.sv | 40 ++++
 rtl/lfsr_rr_sched.sv | 139 +++++++++++++
 tb/tb_lfsr_rr_sched.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/lfsr_pkg.sv
// Shared types and constants for the LFSR-driven round-robin scheduler.
package lfsr_pkg;

    localparam int LFSR_W = 5;
    localparam logic [LFSR_W-1:0] DEFAULT_SEED = 5'b10101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        STEP = 2'd1,
        DONE = 2'd2
    } state_e;

    // Single Fibonacci step: feedback from taps 0 and 3 enters at the MSB.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        return {s[0] ^ s[3], s[4:1]};
    endfunction

endpackage

// File: rtl/lfsr_rr_sched_if.sv
// Request/grant/seed bundle between a requester-side master and the scheduler.
interface lfsr_rr_sched_if #(
    parameter int N_REQ = 4
);
    import lfsr_pkg::*;

    logic [N_REQ-1:0]  req;
    logic              seed_load;
    logic [LFSR_W-1:0] seed_val;
    logic [N_REQ-1:0]  gnt;
    logic              rnd_valid;
    logic [LFSR_W-1:0] rnd_data;
    logic              busy;
    logic              seed_rej;

    modport master (
        output req, seed_load, seed_val,
        input  gnt, rnd_valid, rnd_data, busy, seed_rej
    );

    modport slave (
        input  req, seed_load, seed_val,
        output gnt, rnd_valid, rnd_data, busy, seed_rej
    );

endinterface

// File: rtl/lfsr_core.sv
// 5-bit shift register with parallel load and all-zero lockup recovery.
module lfsr_core
    import lfsr_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = DEFAULT_SEED
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              load,
    input  logic [LFSR_W-1:0] load_val,
    output logic [LFSR_W-1:0] state
);

    logic [LFSR_W-1:0] state_q;
    logic [LFSR_W-1:0] state_d;

    // Load wins; otherwise a zero state is forced back to SEED before any shift.
    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = load_val;
        end else if (state_q == '0) begin
            state_d = SEED;
        end else if (en) begin
            state_d = lfsr_next(state_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/lfsr_rr_sched.sv
// Round-robin arbiter that runs the LFSR STEPS times per grant and hands the
// resulting word to the winner together with a one-cycle grant pulse.
module lfsr_rr_sched
    import lfsr_pkg::*;
#(
    parameter int                N_REQ = 4,
    parameter int                STEPS = 5,
    parameter logic [LFSR_W-1:0] SEED  = DEFAULT_SEED
) (
    input  logic           clk,
    input  logic           rst,
    lfsr_rr_sched_if.slave bus
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [IDX_W-1:0]  win_q, win_d;
    logic [4:0]        cnt_q, cnt_d;
    logic [N_REQ-1:0]  gnt_q, gnt_dec;
    logic              rnd_valid_q;
    logic              seed_rej_q;

    logic              rr_any;
    logic [IDX_W-1:0]  rr_win;
    logic [IDX_W:0]    rr_idx;
    logic [IDX_W-1:0]  rr_idx_n;

    logic              lfsr_load;
    logic [LFSR_W-1:0] lfsr_load_val;
    logic [LFSR_W-1:0] lfsr_state;

    // First set request at or above ptr, wrapping past the top requester.
    always_comb begin
        rr_any   = 1'b0;
        rr_win   = ptr_q;
        rr_idx   = '0;
        rr_idx_n = '0;
        for (int k = 0; k < N_REQ; k++) begin
            rr_idx = {1'b0, ptr_q} + (IDX_W+1)'(k);
            if (rr_idx >= (IDX_W+1)'(N_REQ)) begin
                rr_idx = rr_idx - (IDX_W+1)'(N_REQ);
            end
            rr_idx_n = rr_idx[IDX_W-1:0];
            if (!rr_any && bus.req[rr_idx_n]) begin
                rr_any = 1'b1;
                rr_win = rr_idx_n;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        win_d     = win_q;
        cnt_d     = cnt_q;
        lfsr_load = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.seed_load) begin
                    lfsr_load = 1'b1;
                end else if (rr_any) begin
                    win_d   = rr_win;
                    cnt_d   = '0;
                    state_d = STEP;
                end
            end
            STEP: begin
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'(STEPS - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                ptr_d   = (win_q == IDX_W'(N_REQ - 1)) ? '0 : win_q + IDX_W'(1);
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign lfsr_load_val = (bus.seed_val == '0) ? SEED : bus.seed_val;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            win_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            cnt_q   <= cnt_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_gnt_dec
            assign gnt_dec[gi] = (state_q == DONE) && (win_q == IDX_W'(gi));
        end
    endgenerate

    // Grant, valid and reject are flops decoded from the registered state, so
    // the grant pulse lands on the cycle right after DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt_q       <= '0;
            rnd_valid_q <= 1'b0;
            seed_rej_q  <= 1'b0;
        end else begin
            gnt_q       <= gnt_dec;
            rnd_valid_q <= (state_q == DONE);
            seed_rej_q  <= bus.seed_load && (state_q != IDLE);
        end
    end

    lfsr_core #(
        .SEED (SEED)
    ) u_lfsr (
        .clk      (clk),
        .rst      (rst),
        .en       (state_q == STEP),
        .load     (lfsr_load),
        .load_val (lfsr_load_val),
        .state    (lfsr_state)
    );

    assign bus.gnt       = gnt_q;
    assign bus.rnd_valid = rnd_valid_q;
    assign bus.rnd_data  = lfsr_state;
    assign bus.busy      = (state_q != IDLE);
    assign bus.seed_rej  = seed_rej_q;

endmodule

// File: tb/tb_lfsr_rr_sched.sv
// Directed bench for lfsr_rr_sched with a cycle-level reference model and
// literal spot checks of latency, ordering, seeding and reset recovery.
module tb_lfsr_rr_sched;

    localparam int          N     = 4;
    localparam int          STEPS = 5;
    localparam logic [4:0]  SEED  = 5'b10101;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    lfsr_rr_sched_if #(.N_REQ(N)) bus ();

    lfsr_rr_sched #(
        .N_REQ (N),
        .STEPS (STEPS),
        .SEED  (SEED)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    // Reference model: one LFSR step as plain arithmetic.
    function automatic int lfsr_adv(input int s);
        return ((s >> 1) | (((s ^ (s >> 3)) & 1) << 4)) & 31;
    endfunction

    function automatic int rr_pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return p;
    endfunction

    // m_left counts busy cycles still to run: STEPS shifting cycles then one
    // grant-preparation cycle; the grant is visible the cycle after it ends.
    int m_lfsr = SEED;
    int m_ptr  = 0;
    int m_left = 0;
    int m_win  = 0;
    int m_gnt  = 0;
    int m_valid = 0;
    int m_rej  = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_lfsr <= SEED; m_ptr <= 0; m_left <= 0; m_win <= 0;
            m_gnt <= 0; m_valid <= 0; m_rej <= 0;
        end else begin
            m_gnt   <= 0;
            m_valid <= 0;
            m_rej   <= (bus.seed_load && m_left != 0) ? 1 : 0;
            if (m_left != 0) begin
                if (m_left > 1) begin
                    m_lfsr <= lfsr_adv(m_lfsr);
                end else begin
                    m_gnt   <= 1 << m_win;
                    m_valid <= 1;
                    m_ptr   <= (m_win + 1) % N;
                end
                m_left <= m_left - 1;
            end else if (bus.seed_load) begin
                m_lfsr <= (bus.seed_val == 5'd0) ? int'(SEED) : int'(bus.seed_val);
            end else if (bus.req != '0) begin
                m_win  <= rr_pick(bus.req, m_ptr);
                m_left <= STEPS + 1;
            end
        end
    end

    always @(negedge clk) begin
        chk("cyc_gnt",       int'(bus.gnt),       m_gnt);
        chk("cyc_rnd_valid", int'(bus.rnd_valid), m_valid);
        chk("cyc_busy",      int'(bus.busy),      (m_left != 0) ? 1 : 0);
        chk("cyc_seed_rej",  int'(bus.seed_rej),  m_rej);
        chk("cyc_rnd_data",  int'(bus.rnd_data),  m_lfsr);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant(output int idx, output int word, output int at);
        int found;
        found = 0;
        idx = -1; word = -1; at = -1;
        for (int t = 0; t < 40 && found == 0; t++) begin
            tick();
            if (bus.gnt != '0) begin
                found = 1;
                word  = int'(bus.rnd_data);
                at    = cyc;
                for (int b = 0; b < N; b++) if (bus.gnt[b]) idx = b;
                chk("gnt_onehot", $countones(bus.gnt), 1);
            end
        end
        chk("grant_seen", found, 1);
    endtask

    int gidx[31];
    int gword[31];
    int gat[31];

    initial begin
        int lat, busy_n, idx, word, at, t0, dups, zeros, n_g;
        bus.req = '0; bus.seed_load = 1'b0; bus.seed_val = '0;

        // Reset state
        repeat (3) tick();
        chk("rst_gnt",  int'(bus.gnt), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_valid", int'(bus.rnd_valid), 0);
        chk("rst_data", int'(bus.rnd_data), 5'b10101);
        rst = 1'b0;
        tick();

        // Single request: latency, busy window, first word
        bus.req = 4'b0001;
        tick();
        bus.req = '0;
        lat = 0; busy_n = 0;
        while (bus.gnt == '0 && lat < 30) begin
            if (bus.busy) busy_n++;
            tick();
            lat++;
        end
        chk("s1_latency", lat, 6);
        chk("s1_busy_cycles", busy_n, 6);
        chk("s1_gnt", int'(bus.gnt), 4'b0001);
        chk("s1_valid", int'(bus.rnd_valid), 1);
        chk("s1_word", int'(bus.rnd_data), 5'b11011);
        tick();
        chk("s1_gnt_pulse", int'(bus.gnt), 0);

        // All requesting from reset: order, spacing, full LFSR period
        rst = 1'b1; tick(); rst = 1'b0; tick();
        bus.req = 4'b1111;
        for (int k = 0; k < 31; k++) begin
            wait_grant(idx, word, at);
            if (k == 30) bus.req = '0;
            gidx[k] = idx; gword[k] = word; gat[k] = at;
            chk("s2_order", idx, k % N);
            if (k > 0) chk("s2_spacing", at - gat[k-1], 7);
            $display("grant %0d: idx=%0d word=%05b cycle=%0d", k + 1, idx, word, at);
        end
        chk("s2_first_word", gword[0], 5'b11011);
        chk("s2_word31", gword[30], 5'b10101);
        dups = 0; zeros = 0;
        for (int a = 0; a < 31; a++) begin
            if (gword[a] == 0) zeros++;
            for (int b = a + 1; b < 31; b++) if (gword[a] == gword[b]) dups++;
        end
        chk("s2_distinct", dups, 0);
        chk("s2_nonzero", zeros, 0);

        // Seed loading in IDLE, rejection during STEP
        bus.seed_load = 1'b1; bus.seed_val = 5'b00111; tick();
        bus.seed_load = 1'b0;
        chk("s3_seed_load", int'(bus.rnd_data), 5'b00111);
        bus.seed_load = 1'b1; bus.seed_val = 5'b00000; tick();
        bus.seed_load = 1'b0;
        chk("s3_seed_zero", int'(bus.rnd_data), 5'b10101);
        bus.req = 4'b0100; tick(); bus.req = '0; tick();
        bus.seed_load = 1'b1; bus.seed_val = 5'b00001; tick();
        bus.seed_load = 1'b0;
        chk("s3_rej_pulse", int'(bus.seed_rej), 1);
        chk("s3_rej_busy", int'(bus.busy), 1);
        tick();
        chk("s3_rej_clear", int'(bus.seed_rej), 0);
        wait_grant(idx, word, at);
        chk("s3_gnt_idx", idx, 2);
        chk("s3_word", word, 5'b11011);

        // Seed load and request in the same IDLE cycle
        bus.seed_load = 1'b1; bus.seed_val = 5'b00111; bus.req = 4'b0010;
        tick();
        t0 = cyc;
        bus.seed_load = 1'b0;
        tick();
        bus.req = '0;
        wait_grant(idx, word, at);
        chk("s4_latency", at - t0, 7);
        chk("s4_gnt_idx", idx, 1);
        chk("s4_word", word, 5'b01011);

        // Reset in the third STEP cycle abandons the grant
        bus.req = 4'b1000; tick(); bus.req = '0; tick(); tick();
        rst = 1'b1;
        #2;
        chk("s5_rst_gnt", int'(bus.gnt), 0);
        chk("s5_rst_busy", int'(bus.busy), 0);
        chk("s5_rst_valid", int'(bus.rnd_valid), 0);
        chk("s5_rst_rej", int'(bus.seed_rej), 0);
        chk("s5_rst_data", int'(bus.rnd_data), 5'b10101);
        tick();
        rst = 1'b0;
        n_g = 0;
        for (int t = 0; t < 10; t++) begin
            tick();
            if (bus.gnt != '0) n_g++;
        end
        chk("s5_no_grant", n_g, 0);
        bus.req = 4'b0110; tick(); bus.req = '0;
        wait_grant(idx, word, at);
        chk("s5_gnt_idx", idx, 1);
        chk("s5_word", word, 5'b11011);

        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
